// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU opcode definitions and helpers for the
// shift-and-add multiply sequencer.
package alu_mul_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_SLT = 3'd7
    } alu_op_t;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/alu_mul_step.sv
// One shift-and-add multiply step: picks the ALU sum or a plain
// shift depending on the multiplier LSB, and reports whether it may commit.
module alu_mul_step #(
    parameter int WORD_WIDTH = 32
) (
    input  logic [WORD_WIDTH-1:0] acc_hi,
    input  logic [WORD_WIDTH-1:0] acc_lo,
    input  logic [WORD_WIDTH-1:0] alu_out,
    input  logic                  alu_oc,
    input  logic                  alu_grant,
    output logic [WORD_WIDTH-1:0] hi_nxt,
    output logic [WORD_WIDTH-1:0] lo_nxt,
    output logic                  need,
    output logic                  commit
);

    logic [WORD_WIDTH-1:0] sum;
    logic                  co;

    always_comb begin
        need   = acc_lo[0];
        sum    = need ? alu_out : acc_hi;
        co     = need & alu_oc;
        // A skip step never touches the adder, so it never waits on grant.
        commit = ~need | alu_grant;
        hi_nxt = {co, sum[WORD_WIDTH-1:1]};
        lo_nxt = {sum[0], acc_lo[WORD_WIDTH-1:1]};
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned multiplier that borrows the core's shared ALU adder
// only on iterations that need an add.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] mcand,
    input  logic [WORD_WIDTH-1:0] mplier,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] result_hi,
    output logic [WORD_WIDTH-1:0] result_lo,
    output logic                  alu_req,
    input  logic                  alu_grant,
    output logic [WORD_WIDTH-1:0] alu_a,
    output logic [WORD_WIDTH-1:0] alu_b,
    output logic                  alu_ic,
    output logic [2:0]            alu_opcode,
    input  logic [WORD_WIDTH-1:0] alu_out,
    input  logic                  alu_oc
);

    localparam int CW = cnt_width(WORD_WIDTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [WORD_WIDTH-1:0] acc_hi;
    logic [WORD_WIDTH-1:0] acc_lo;
    logic [WORD_WIDTH-1:0] mcand_r;
    logic [WORD_WIDTH-1:0] hi_nxt;
    logic [WORD_WIDTH-1:0] lo_nxt;
    logic [CW-1:0]         count;
    logic                  need;
    logic                  commit;
    logic                  run;
    logic                  last;

    alu_mul_step #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_step (
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo),
        .alu_out  (alu_out),
        .alu_oc   (alu_oc),
        .alu_grant(alu_grant),
        .hi_nxt   (hi_nxt),
        .lo_nxt   (lo_nxt),
        .need     (need),
        .commit   (commit)
    );

    assign run  = (state == RUN);
    assign last = run && commit &&
                  (count == CW'(WORD_WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = run;
        alu_req = run & need;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_hi  <= '0;
            acc_lo  <= '0;
            mcand_r <= '0;
            count   <= '0;
        end else if (!run && start) begin
            acc_hi  <= '0;
            acc_lo  <= mplier;
            mcand_r <= mcand;
            count   <= '0;
        end else if (run && commit) begin
            acc_hi  <= hi_nxt;
            acc_lo  <= lo_nxt;
            count   <= count + CW'(1);
        end
    end

    // Results only move on the final commit, so they stay stable during RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done      <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            done <= last;
            if (last) begin
                result_hi <= hi_nxt;
                result_lo <= lo_nxt;
            end
        end
    end

    assign alu_a      = acc_hi;
    assign alu_b      = mcand_r;
    assign alu_ic     = 1'b0;
    assign alu_opcode = OP_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized and directed bench for alu_mul_seq against a
// product-level reference model.
module tb_alu_mul_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic          busy;
    logic          done;
    logic [W-1:0]  result_hi;
    logic [W-1:0]  result_lo;
    logic          alu_req;
    logic          alu_grant;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic          alu_ic;
    logic [2:0]    alu_opcode;
    logic [W-1:0]  alu_out;
    logic          alu_oc;

    always #5 clk = ~clk;

    assign {alu_oc, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};

    alu_mul_seq #(.WORD_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mcand     (mcand),
        .mplier    (mplier),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo),
        .alu_req   (alu_req),
        .alu_grant (alu_grant),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ic    (alu_ic),
        .alu_opcode(alu_opcode),
        .alu_out   (alu_out),
        .alu_oc    (alu_oc)
    );

    int checks = 0;
    int errors = 0;

    bit          m_run;
    bit          m_done;
    int          m_step;
    logic [W-1:0] m_mc;
    logic [W-1:0] m_mp;
    logic [63:0] m_res;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_clear();
        m_run  = 0;
        m_done = 0;
        m_step = 0;
        m_mc   = '0;
        m_mp   = '0;
        m_res  = '0;
    endtask

    function automatic bit m_req();
        return m_run && m_mp[m_step];
    endfunction

    // High word of the partial product after m_step multiplier bits.
    function automatic logic [63:0] exp_a();
        logic [63:0] part;
        part = {32'b0, m_mp} & ((64'd1 << m_step) - 64'd1);
        return ({32'b0, m_mc} * part) >> m_step;
    endfunction

    task automatic compare();
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("alu_req", alu_req, m_req());
        chk("result_hi", result_hi, m_res[63:32]);
        chk("result_lo", result_lo, m_res[31:0]);
        chk("alu_b", alu_b, m_mc);
        chk("alu_ic", alu_ic, 0);
        chk("alu_opcode", alu_opcode, 0);
        if (m_run) chk("alu_a", alu_a, exp_a());
    endtask

    task automatic model_update();
        if (reset) begin
            m_clear();
        end else begin
            m_done = 0;
            if (!m_run) begin
                if (start) begin
                    m_run  = 1;
                    m_step = 0;
                    m_mc   = mcand;
                    m_mp   = mplier;
                end
            end else if (!m_mp[m_step] || alu_grant) begin
                m_step++;
                if (m_step == W) begin
                    m_run  = 0;
                    m_done = 1;
                    m_res  = {32'b0, m_mc} * {32'b0, m_mp};
                end
            end
        end
    endtask

    task automatic tick();
        compare();
        model_update();
        @(negedge clk);
    endtask

    // gmode: 0 grant tied 1, 1 tied 0, 2 random, 3 deny first nstall requests
    task automatic run_op(
        input logic [W-1:0] mc, input logic [W-1:0] mp,
        input bit do_start, input int gmode, input int nstall,
        input int repulse_at, input int rst_at, input bit chain,
        input logic [W-1:0] mc2, input logic [W-1:0] mp2,
        output int lat, output int reqs, output logic [63:0] res);
        int stalled;
        lat = 0;
        reqs = 0;
        res = '0;
        stalled = 0;
        if (do_start) begin
            start = 1;
            mcand = mc;
            mplier = mp;
            alu_grant = (gmode != 1);
            tick();
        end
        for (int i = 1; i < 200; i++) begin
            start = 0;
            if (i == repulse_at) begin
                start = 1;
                mcand = ~mc;
                mplier = mp ^ 32'h5a5a_0f0f;
            end
            if (rst_at != 0 && i == rst_at) begin
                reset = 1;
                m_clear();
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_req", alu_req, 0);
                chk("rst_res", {result_hi, result_lo}, 0);
            end
            if (rst_at != 0 && i == rst_at + 2) reset = 0;
            case (gmode)
                0: alu_grant = 1;
                1: alu_grant = 0;
                2: alu_grant = ($urandom_range(0, 3) != 0);
                default: begin
                    if (m_req() && stalled < nstall) begin
                        alu_grant = 0;
                        stalled++;
                    end else begin
                        alu_grant = 1;
                    end
                end
            endcase
            if (alu_req) reqs++;
            if (done) begin
                lat = i;
                res = {result_hi, result_lo};
                if (chain) begin
                    start = 1;
                    mcand = mc2;
                    mplier = mp2;
                end
                tick();
                start = 0;
                break;
            end
            tick();
            if (rst_at != 0 && i >= 60) break;
        end
        if (lat == 0 && rst_at == 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        int reqs;
        logic [63:0] res;
        logic [W-1:0] a;
        logic [W-1:0] b;

        reset = 1;
        start = 0;
        mcand = '0;
        mplier = '0;
        alu_grant = 0;
        m_clear();
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_result", {result_hi, result_lo}, 0);
        tick();
        reset = 0;
        tick();

        run_op(3, 5, 1, 0, 0, 0, 0, 0, 0, 0, lat, reqs, res);
        chk("t1_lat", lat, 33);
        chk("t1_res", res, 64'h0000_000F);

        run_op('1, '1, 1, 0, 0, 0, 0, 0, 0, 0, lat, reqs, res);
        chk("t2_lat", lat, 33);
        chk("t2_res", res, 64'hFFFF_FFFE_0000_0001);
        chk("t2_reqs", reqs, 32);

        run_op(32'h1234, 0, 1, 1, 0, 0, 0, 0, 0, 0, lat, reqs, res);
        chk("t3_lat", lat, 33);
        chk("t3_res", res, 0);
        chk("t3_reqs", reqs, 0);

        run_op(7, 32'h8000_0000, 1, 3, 5, 0, 0, 0, 0, 0, lat, reqs, res);
        chk("t4_lat", lat, 38);
        chk("t4_res", res, 64'h0000_0003_8000_0000);
        chk("t4_reqs", reqs, 6);

        run_op(3, 5, 1, 0, 0, 10, 0, 1, 11, 13, lat, reqs, res);
        chk("t5_lat", lat, 33);
        chk("t5_res", res, 64'd15);
        chk("t5_chain_busy", busy, 1);
        run_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, lat, reqs, res);
        chk("t5b_lat", lat, 33);
        chk("t5b_res", res, 64'd143);

        run_op(32'hFFFF, 32'hFFFF, 1, 0, 0, 0, 15, 0, 0, 0, lat, reqs, res);
        chk("t6_no_done", lat, 0);
        run_op(6, 7, 1, 0, 0, 0, 0, 0, 0, 0, lat, reqs, res);
        chk("t6_lat", lat, 33);
        chk("t6_res", res, 64'd42);

        for (int k = 0; k < 40; k++) begin
            a = $urandom();
            b = $urandom();
            if (k % 10 == 3) a = '1;
            if (k % 10 == 7) b = 0;
            run_op(a, b, 1, 2, 0,
                   ($urandom_range(0, 1) != 0) ? $urandom_range(2, 20) : 0,
                   0, 0, 0, 0, lat, reqs, res);
            chk("rand_res", res, {32'b0, a} * {32'b0, b});
            chk("rand_lat_min", (lat >= 33), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
